decode_stage: RTL and testbench



---
 rtl/decode_stage_pkg.sv | 74 +++++++
 rtl/decode_stage_if.sv | 55 +++++
 rtl/decode_stage_imm_gen.sv | 42 ++++
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage and its helpers:
//   - RV base opcode constants
//   - funct3 / funct7 values that the legality checks key on
//   - imm_type_t, the immediate-format selector (also an output of the stage)
//   - decode_fields_t, the XLEN-independent part of the decoded bundle
//   - shiftImmUpperOk(), legality of the upper bits of a shift-immediate
// ---------------------------------------------------------------------------
package decode_stage_pkg;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [2:0] F3_JALR     = 3'b000;
   localparam logic [2:0] F3_BR_RSV0  = 3'b010;
   localparam logic [2:0] F3_BR_RSV1  = 3'b011;
   localparam logic [2:0] F3_LD       = 3'b011;
   localparam logic [2:0] F3_LWU      = 3'b110;
   localparam logic [2:0] F3_LD_RSV   = 3'b111;
   localparam logic [2:0] F3_SD       = 3'b011;
   localparam logic [2:0] F3_SLL      = 3'b001;
   localparam logic [2:0] F3_SR       = 3'b101;
   localparam logic [2:0] F3_ADDSUB   = 3'b000;

   localparam logic [6:0] F7_BASE     = 7'b0000000;
   localparam logic [6:0] F7_ALT      = 7'b0100000;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      imm_type_t  immType;
      logic       rs1Used;
      logic       rs2Used;
      logic       rdWe;
      logic       illegal;
   } decode_fields_t;

   // On RV64 bit 25 belongs to the 6-bit shift amount, so it is masked out
   // before comparing the remaining upper bits against the allowed patterns.
   function automatic logic shiftImmUpperOk(input logic [31:25] upper,
                                            input logic       allowAlt,
                                            input logic       rv64);
      logic [6:0] bits;
      bits = upper;
      if (rv64) begin
         bits[0] = 1'b0;
      end
      return (bits == F7_BASE) || (allowAlt && (bits == F7_ALT));
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Handshake and bus signals around the decode stage.
//   Input side : in_valid, in_ready, in_instr, in_pc, flush
//   Output side: out_valid, out_ready, out_pc, out_opcode, out_rd, out_rs1,
//                out_rs2, out_funct3, out_funct7, out_imm, out_imm_type,
//                out_rs1_used, out_rs2_used, out_rd_we, out_illegal
// Modports:
//   master - the surrounding pipeline (fetch drives the input side,
//            execute consumes the output side)
//   slave  - the decode stage itself
// ---------------------------------------------------------------------------
interface decode_stage_if
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) ();

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   imm_type_t       out_imm_type;
   logic            out_rs1_used;
   logic            out_rs2_used;
   logic            out_rd_we;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1,
             out_rs2, out_funct3, out_funct7, out_imm, out_imm_type,
             out_rs1_used, out_rs2_used, out_rd_we, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1,
             out_rs2, out_funct3, out_funct7, out_imm, out_imm_type,
             out_rs1_used, out_rs2_used, out_rd_we, out_illegal
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator: picks the immediate bit layout for the
// requested format and sign-extends from instr[31] to XLEN bits. IMM_NONE
// (and any unused encoding) yields zero.
// Ports:
//   instr_i   in  [31:7]  instruction bits above the opcode
//   immType_i in  3       imm_type_t format selector
//   imm_o     out XLEN    sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr_i,
   input  imm_type_t       immType_i,
   output logic [XLEN-1:0] imm_o
);

   logic signBit;

   assign signBit = instr_i[31];

   // Each format reassembles its scattered immediate bits; the replication
   // count always stays at least one so the same expressions work for both
   // datapath widths.
   always_comb begin
      imm_o = '0;
      case (immType_i)
         IMM_I: imm_o = {{(XLEN-11){signBit}}, instr_i[30:20]};
         IMM_S: imm_o = {{(XLEN-11){signBit}}, instr_i[30:25], instr_i[11:7]};
         IMM_B: imm_o = {{(XLEN-12){signBit}}, instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
         IMM_U: imm_o = {{(XLEN-31){signBit}}, instr_i[30:12], 12'b0};
         IMM_J: imm_o = {{(XLEN-20){signBit}}, instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered instruction decoder between fetch and register-read. Each
// accepted instruction is classified (immediate format, operand usage,
// writeback, legality), its immediate is generated, and the whole bundle is
// held in a single output register behind a valid/ready handshake.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    decode_stage_if.slave - fetch-side handshake, flush, and the
//          registered decoded bundle towards execute
// Parameters:
//   XLEN          32 or 64; pc/immediate width and RV64 load/store legality
//   HOLD_ON_FLUSH 1: flush is ignored while the output is stalled
// ---------------------------------------------------------------------------
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter bit HOLD_ON_FLUSH = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);

   localparam logic RV64 = (XLEN == 64);

   logic [31:0]     instr;
   decode_fields_t  decoded;
   logic [XLEN-1:0] immNew;
   logic            capture;
   logic            flushTakes;

   logic            outValid_q;
   logic            outValid_d;
   decode_fields_t  fields_q;
   decode_fields_t  fields_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] imm_d;

   assign instr = bus.in_instr;

   // Classifier: raw fields are always passed through, then the opcode picks
   // the immediate format and operand flags, and the per-opcode rules decide
   // legality. An illegal word keeps its raw fields but loses its immediate
   // format and every usage/writeback flag, so execute never acts on it.
   always_comb begin
      decoded         = '0;
      decoded.opcode  = instr[6:0];
      decoded.rd      = instr[11:7];
      decoded.funct3  = instr[14:12];
      decoded.rs1     = instr[19:15];
      decoded.rs2     = instr[24:20];
      decoded.funct7  = instr[31:25];
      decoded.immType = IMM_NONE;
      decoded.illegal = (instr[1:0] != 2'b11);

      case (decoded.opcode)
         OPC_LUI, OPC_AUIPC: begin
            decoded.immType = IMM_U;
            decoded.rdWe    = 1'b1;
         end
         OPC_JAL: begin
            decoded.immType = IMM_J;
            decoded.rdWe    = 1'b1;
         end
         OPC_JALR: begin
            decoded.immType = IMM_I;
            decoded.rs1Used = 1'b1;
            decoded.rdWe    = 1'b1;
            if (decoded.funct3 != F3_JALR) decoded.illegal = 1'b1;
         end
         OPC_LOAD: begin
            decoded.immType = IMM_I;
            decoded.rs1Used = 1'b1;
            decoded.rdWe    = 1'b1;
            if ((decoded.funct3 == F3_LD_RSV) ||
                (!RV64 && ((decoded.funct3 == F3_LD) || (decoded.funct3 == F3_LWU))))
               decoded.illegal = 1'b1;
         end
         OPC_OPIMM: begin
            decoded.immType = IMM_I;
            decoded.rs1Used = 1'b1;
            decoded.rdWe    = 1'b1;
            if ((decoded.funct3 == F3_SLL) && !shiftImmUpperOk(instr[31:25], 1'b0, RV64))
               decoded.illegal = 1'b1;
            if ((decoded.funct3 == F3_SR) && !shiftImmUpperOk(instr[31:25], 1'b1, RV64))
               decoded.illegal = 1'b1;
         end
         OPC_SYSTEM, OPC_MISCMEM: begin
            decoded.immType = IMM_I;
         end
         OPC_STORE: begin
            decoded.immType = IMM_S;
            decoded.rs1Used = 1'b1;
            decoded.rs2Used = 1'b1;
            if (decoded.funct3[2] || (!RV64 && (decoded.funct3 == F3_SD)))
               decoded.illegal = 1'b1;
         end
         OPC_BRANCH: begin
            decoded.immType = IMM_B;
            decoded.rs1Used = 1'b1;
            decoded.rs2Used = 1'b1;
            if ((decoded.funct3 == F3_BR_RSV0) || (decoded.funct3 == F3_BR_RSV1))
               decoded.illegal = 1'b1;
         end
         OPC_OP: begin
            decoded.rs1Used = 1'b1;
            decoded.rs2Used = 1'b1;
            decoded.rdWe    = 1'b1;
            if ((decoded.funct7 != F7_BASE) && (decoded.funct7 != F7_ALT))
               decoded.illegal = 1'b1;
            if ((decoded.funct7 == F7_ALT) &&
                (decoded.funct3 != F3_ADDSUB) && (decoded.funct3 != F3_SR))
               decoded.illegal = 1'b1;
         end
         default: begin
            decoded.illegal = 1'b1;
         end
      endcase

      // Writes to x0 are architecturally dropped, so they never request writeback.
      decoded.rdWe = decoded.rdWe && (decoded.rd != 5'd0);

      if (decoded.illegal) begin
         decoded.immType = IMM_NONE;
         decoded.rs1Used = 1'b0;
         decoded.rs2Used = 1'b0;
         decoded.rdWe    = 1'b0;
      end
   end

   imm_gen #(
      .XLEN (XLEN)
   ) uImmGen (
      .instr_i   (instr[31:7]),
      .immType_i (decoded.immType),
      .imm_o     (immNew)
   );

   // The stage can take a new word whenever its single slot is empty or is
   // being drained this cycle; in_valid deliberately plays no part here.
   assign bus.in_ready = !outValid_q || bus.out_ready;
   assign capture      = bus.in_valid && bus.in_ready;

   // With HOLD_ON_FLUSH set, a stalled bundle is protected from flush so the
   // consumer still sees it once it becomes ready.
   assign flushTakes = bus.flush &&
                       !(HOLD_ON_FLUSH && outValid_q && !bus.out_ready);

   // Next-state for the output slot in priority order flush > capture > drain.
   // Data only moves on capture, which keeps every field bit-stable during a
   // stall; a flush or drain simply clears valid.
   always_comb begin
      outValid_d = outValid_q;
      fields_d   = fields_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      if (flushTakes) begin
         outValid_d = 1'b0;
      end else if (capture) begin
         outValid_d = 1'b1;
         fields_d   = decoded;
         pc_d       = bus.in_pc;
         imm_d      = immNew;
      end else if (bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register; reset clears the held bundle entirely, including data,
   // so downstream sees an all-zero bundle with IMM_NONE after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         fields_q   <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
      end else begin
         outValid_q <= outValid_d;
         fields_q   <= fields_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
      end
   end

   assign bus.out_valid    = outValid_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_opcode   = fields_q.opcode;
   assign bus.out_rd       = fields_q.rd;
   assign bus.out_rs1      = fields_q.rs1;
   assign bus.out_rs2      = fields_q.rs2;
   assign bus.out_funct3   = fields_q.funct3;
   assign bus.out_funct7   = fields_q.funct7;
   assign bus.out_imm      = imm_q;
   assign bus.out_imm_type = fields_q.immType;
   assign bus.out_rs1_used = fields_q.rs1Used;
   assign bus.out_rs2_used = fields_q.rs2Used;
   assign bus.out_rd_we    = fields_q.rdWe;
   assign bus.out_illegal  = fields_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Drives decode_stage (XLEN=32, HOLD_ON_FLUSH=0) through directed scenarios
// and a randomized run, comparing every cycle against a reference model that
// decodes instructions with plain arithmetic and tracks the one-slot stage.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst_n;

   decode_stage_if #(.XLEN(XLEN)) bus ();

   decode_stage #(
      .XLEN          (XLEN),
      .HOLD_ON_FLUSH (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic [2:0]  immType;
      logic        rs1Used;
      logic        rs2Used;
      logic        rdWe;
      logic        illegal;
   } expect_t;

   int checkCount = 0;
   int errorCount = 0;

   // Model of the stage slot
   bit          mKnown = 1'b0;
   bit          mValid = 1'b0;
   bit          mReset = 1'b0;
   logic [31:0] mInstr = '0;
   logic [31:0] mPc    = '0;

   logic [6:0] opcTable [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                 7'h73, 7'h0F, 7'h23, 7'h63, 7'h33};

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference decode, RV32 rules, written from the instruction-set view.
   function automatic expect_t refDecode(input logic [31:0] w, input logic [31:0] pc);
      expect_t     e;
      logic [31:0] sx;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          legal;
      int          fmt;
      bit          r1;
      bit          r2;
      bit          wr;
      f3    = w[14:12];
      f7    = w[31:25];
      sx    = w[31] ? 32'hFFFF_FFFF : 32'h0;
      legal = 1'b1;
      fmt   = 0;
      r1    = 1'b0;
      r2    = 1'b0;
      wr    = 1'b0;
      case (w[6:0])
         7'h37, 7'h17: begin fmt = 4; wr = 1'b1; end
         7'h6F:        begin fmt = 5; wr = 1'b1; end
         7'h67:        begin fmt = 1; r1 = 1'b1; wr = 1'b1; legal = (f3 == 3'd0); end
         7'h03:        begin fmt = 1; r1 = 1'b1; wr = 1'b1;
                             legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
         7'h13: begin
            fmt = 1; r1 = 1'b1; wr = 1'b1;
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
         end
         7'h73, 7'h0F: fmt = 1;
         7'h23:        begin fmt = 2; r1 = 1'b1; r2 = 1'b1; legal = (f3 <= 3'd2); end
         7'h63:        begin fmt = 3; r1 = 1'b1; r2 = 1'b1;
                             legal = !(f3 == 3'd2 || f3 == 3'd3); end
         7'h33: begin
            fmt = 0; r1 = 1'b1; r2 = 1'b1; wr = 1'b1;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         default: legal = 1'b0;
      endcase
      case (fmt)
         1: imm = (sx << 12) | {20'b0, w[31:20]};
         2: imm = (sx << 12) | {20'b0, w[31:25], w[11:7]};
         3: imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         4: imm = w & 32'hFFFF_F000;
         5: imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         default: imm = 32'h0;
      endcase
      e.pc      = pc;
      e.opcode  = w[6:0];
      e.rd      = w[11:7];
      e.rs1     = w[19:15];
      e.rs2     = w[24:20];
      e.funct3  = f3;
      e.funct7  = f7;
      e.illegal = !legal;
      e.imm     = legal ? imm : 32'h0;
      e.immType = legal ? 3'(fmt) : 3'd0;
      e.rs1Used = legal && r1;
      e.rs2Used = legal && r2;
      e.rdWe    = legal && wr && (w[11:7] != 5'd0);
      return e;
   endfunction

   // Compares the registered bundle against the model after each edge.
   task automatic checkBundle();
      expect_t e;
      checkOutput("out_valid", bus.out_valid, mValid);
      if (mReset || mValid) begin
         if (mReset) e = '{default: '0};
         else        e = refDecode(mInstr, mPc);
         checkOutput("out_pc",       bus.out_pc,       e.pc);
         checkOutput("out_opcode",   bus.out_opcode,   e.opcode);
         checkOutput("out_rd",       bus.out_rd,       e.rd);
         checkOutput("out_rs1",      bus.out_rs1,      e.rs1);
         checkOutput("out_rs2",      bus.out_rs2,      e.rs2);
         checkOutput("out_funct3",   bus.out_funct3,   e.funct3);
         checkOutput("out_funct7",   bus.out_funct7,   e.funct7);
         checkOutput("out_imm",      bus.out_imm,      e.imm);
         checkOutput("out_imm_type", bus.out_imm_type, e.immType);
         checkOutput("out_rs1_used", bus.out_rs1_used, e.rs1Used);
         checkOutput("out_rs2_used", bus.out_rs2_used, e.rs2Used);
         checkOutput("out_rd_we",    bus.out_rd_we,    e.rdWe);
         checkOutput("out_illegal",  bus.out_illegal,  e.illegal);
      end
   endtask

   // One clock of stimulus: drive, check in_ready, advance model, clock, check.
   task automatic applyStimulus(input bit inValid, input logic [31:0] instr,
                                input logic [31:0] pc, input bit fl,
                                input bit outReady, input bit rstn);
      bit expReady;
      rst_n         = rstn;
      bus.in_valid  = inValid;
      bus.in_instr  = instr;
      bus.in_pc     = pc;
      bus.flush     = fl;
      bus.out_ready = outReady;
      #1;
      expReady = !mValid || outReady;
      if (mKnown) checkOutput("in_ready", bus.in_ready, expReady);
      if (!rstn) begin
         mValid = 1'b0;
         mReset = 1'b1;
         mKnown = 1'b1;
      end else if (fl) begin
         mValid = 1'b0;
      end else if (inValid && expReady) begin
         mValid = 1'b1;
         mReset = 1'b0;
         mInstr = instr;
         mPc    = pc;
      end else if (outReady) begin
         mValid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkBundle();
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      int          pick;
      w    = $urandom;
      pick = $urandom_range(0, 13);
      if (pick < 11) w[6:0] = opcTable[pick];
      case ($urandom_range(0, 2))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   logic [31:0] snapPc;
   logic [31:0] snapImm;

   initial begin
      // Reset
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("rst_imm_type", bus.out_imm_type, 3'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("rst_in_ready", bus.in_ready, 1'b1);

      // addi x1,x2,-1
      applyStimulus(1'b1, 32'hFFF1_0093, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
      checkOutput("addi_valid", bus.out_valid, 1'b1);
      checkOutput("addi_rd", bus.out_rd, 5'd1);
      checkOutput("addi_rs1", bus.out_rs1, 5'd2);
      checkOutput("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
      checkOutput("addi_type", bus.out_imm_type, 3'd1);
      checkOutput("addi_rd_we", bus.out_rd_we, 1'b1);
      checkOutput("addi_rs2_used", bus.out_rs2_used, 1'b0);

      // sw then beq back to back
      applyStimulus(1'b1, 32'h0011_2223, 32'h0000_0104, 1'b0, 1'b1, 1'b1);
      checkOutput("sw_imm", bus.out_imm, 32'h4);
      checkOutput("sw_type", bus.out_imm_type, 3'd2);
      checkOutput("sw_rs_used", {bus.out_rs1_used, bus.out_rs2_used, bus.out_rd_we}, 3'b110);
      applyStimulus(1'b1, 32'hFE00_0EE3, 32'h0000_0108, 1'b0, 1'b1, 1'b1);
      checkOutput("beq_no_bubble", bus.out_valid, 1'b1);
      checkOutput("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
      checkOutput("beq_type", bus.out_imm_type, 3'd3);

      // lui and jal x0
      applyStimulus(1'b1, 32'h1234_52B7, 32'h0000_010C, 1'b0, 1'b1, 1'b1);
      checkOutput("lui_imm", bus.out_imm, 32'h1234_5000);
      checkOutput("lui_flags", {bus.out_rd_we, bus.out_rs1_used}, 2'b10);
      applyStimulus(1'b1, 32'h0080_006F, 32'h0000_0110, 1'b0, 1'b1, 1'b1);
      checkOutput("jal_imm", bus.out_imm, 32'h8);
      checkOutput("jal_type", bus.out_imm_type, 3'd5);
      checkOutput("jal_rd_we", bus.out_rd_we, 1'b0);

      // Illegal words still transfer
      applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0114, 1'b0, 1'b1, 1'b1);
      checkOutput("zero_illegal", {bus.out_valid, bus.out_illegal}, 2'b11);
      applyStimulus(1'b1, 32'h0000_7003, 32'h0000_0118, 1'b0, 1'b1, 1'b1);
      checkOutput("ld111_illegal", bus.out_illegal, 1'b1);
      checkOutput("ld111_flags", {bus.out_rs1_used, bus.out_rs2_used, bus.out_rd_we}, 3'b000);
      applyStimulus(1'b1, 32'h0001_3083, 32'h0000_011C, 1'b0, 1'b1, 1'b1);
      checkOutput("ld_rv32_illegal", bus.out_illegal, 1'b1);
      checkOutput("ld_rv32_imm", bus.out_imm, 32'h0);

      // Backpressure: held bundle stays stable, queued word follows
      applyStimulus(1'b1, 32'h0050_0113, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
      snapPc  = bus.out_pc;
      snapImm = bus.out_imm;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h0030_8193, 32'h0000_0204, 1'b0, 1'b0, 1'b1);
         checkOutput("stall_in_ready", bus.in_ready, 1'b0);
         checkOutput("stall_pc_stable", bus.out_pc, snapPc);
         checkOutput("stall_imm_stable", bus.out_imm, snapImm);
      end
      applyStimulus(1'b1, 32'h0030_8193, 32'h0000_0204, 1'b0, 1'b1, 1'b1);
      checkOutput("queued_pc", bus.out_pc, 32'h0000_0204);
      checkOutput("queued_imm", bus.out_imm, 32'h3);

      // Flush with a held bundle and a new word offered
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0011_2223, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
      checkOutput("flush_valid", bus.out_valid, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("flush_no_emit", bus.out_valid, 1'b0);

      // Reset in the middle of a stall
      applyStimulus(1'b1, 32'hFFF1_0093, 32'h0000_0400, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0011_2223, 32'h0000_0404, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0011_2223, 32'h0000_0404, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_stall_valid", bus.out_valid, 1'b0);
      checkOutput("rst_stall_imm", bus.out_imm, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                       $urandom_range(0, 59) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
